// File: rtl/stream_majority_voter.sv
`default_nettype none
// ============================================================================
// Module      : stream_majority_voter
// Description : Streaming population-count voter. Accepts a WIDTH-bit vote
//               vector as BEATS beats of CHUNK bits over valid/ready,
//               accumulates the number of ones and presents a registered
//               vote decision plus the final count over valid/ready.
//               Optional feature macro: VOTER_THRESH_EN (vote = count >= thr);
//               when undefined the fixed strict-majority rule applies.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_majority_voter #(
  parameter int WIDTH = 1001,
  parameter int CHUNK = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CHUNK-1:0]                 in_data,
  input  logic [$clog2(WIDTH+1)-1:0]       thr,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_vote,
  output logic [$clog2(WIDTH+1)-1:0]       out_count
);

  localparam int BEATS = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int CNT_W = $clog2(WIDTH + 1);

  // Beat index width; a single-beat vector still needs one bit of storage.
  localparam int c_beat_w = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Number of meaningful bits in the final beat and the mask selecting them.
  localparam int c_last_bits = WIDTH - (BEATS - 1) * CHUNK;
  localparam logic [CHUNK-1:0] c_last_mask = {CHUNK{1'b1}} >> (CHUNK - c_last_bits);
  localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(BEATS - 1);
  localparam logic [CNT_W-1:0] c_majority = CNT_W'(WIDTH / 2 + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [c_beat_w-1:0] r_beat;
  logic [CNT_W-1:0]    r_acc;
  logic                r_out_valid;
  logic                r_out_vote;
  logic [CNT_W-1:0]    r_out_count;

  logic                w_accept;
  logic                w_is_last;
  logic [CHUNK-1:0]    w_beat_bits;
  logic [CNT_W-1:0]    w_pop;
  logic [CNT_W-1:0]    w_sum;
  logic                w_vote;

  assign in_ready    = (r_state != DONE);
  assign w_accept    = in_valid && in_ready;
  assign w_is_last   = (r_beat == c_last_beat);
  // Bits beyond WIDTH in the last beat are padding and never counted.
  assign w_beat_bits = w_is_last ? (in_data & c_last_mask) : in_data;
  // Accumulator is zero in IDLE, so one adder serves both first and later beats.
  assign w_sum       = r_acc + w_pop;

`ifdef VOTER_THRESH_EN
  assign w_vote = (w_sum >= thr);
`else
  // thr is present for interface compatibility and has no effect on the vote.
  assign w_vote = (w_sum >= c_majority) | (1'b0 & (^thr));
`endif

  // Population count of the (masked) incoming beat.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < CHUNK; i++) begin
      w_pop = w_pop + CNT_W'(w_beat_bits[i]);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: collect beats, then hold the result until the sink takes it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = w_is_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (w_accept && w_is_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: accumulate beats, capture the result on the last beat, clear on hand-off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat      <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_vote  <= 1'b0;
      r_out_count <= '0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      if (w_is_last) begin
        r_out_valid <= 1'b1;
        r_out_vote  <= w_vote;
        r_out_count <= w_sum;
      end else begin
        r_beat <= r_beat + 1'b1;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_beat      <= '0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_vote  = r_out_vote;
  assign out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_stream_majority_voter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_majority_voter
// Description : Directed self-checking bench for stream_majority_voter with
//               WIDTH=1001, CHUNK=64 (16 beats, 41 valid bits in last beat).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_majority_voter;

  localparam int WIDTH = 1001;
  localparam int CHUNK = 64;
  localparam int BEATS = 16;
  localparam int CNT_W = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [CHUNK-1:0] in_data;
  logic [CNT_W-1:0] thr;
  logic             out_valid;
  logic             out_ready;
  logic             out_vote;
  logic [CNT_W-1:0] out_count;

  int total = 0;
  int bad   = 0;

  stream_majority_voter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .thr      (thr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_vote (out_vote),
    .out_count(out_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Vector with the low n bits set.
  function automatic logic [1023:0] ones(input int n);
    logic [1023:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Drive all 16 beats back-to-back; returns at #1 after the last accepting edge.
  task automatic drive_vec(input logic [1023:0] v);
    for (int b = 0; b < BEATS; b++) begin
      in_valid = 1'b1;
      in_data  = v[b*CHUNK +: CHUNK];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // One-cycle result hand-off.
  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; thr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_vote !== 1'b0) begin bad++; $display("FAIL reset_out_vote got=%b exp=0", out_vote); end
    total++; if (out_count !== 10'd0) begin bad++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
  endtask

  task automatic test_all_ones();
    logic [1023:0] v;
    v = ~1024'd0;
    for (int b = 0; b < BEATS - 1; b++) begin
      in_valid = 1'b1; in_data = v[b*CHUNK +: CHUNK];
      @(posedge clk); #1;
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL all_ones_early_valid got=%b exp=0", out_valid); end
    in_data = v[15*CHUNK +: CHUNK];
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL all_ones_valid got=%b exp=1", out_valid); end
    total++; if (out_count !== 10'd1001) begin bad++; $display("FAIL all_ones_count got=%0d exp=1001", out_count); end
    total++; if (out_vote !== 1'b1) begin bad++; $display("FAIL all_ones_vote got=%b exp=1", out_vote); end
    release_result();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL all_ones_release_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL all_ones_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_majority_edge();
    drive_vec(ones(501));
    total++; if (out_count !== 10'd501) begin bad++; $display("FAIL maj501_count got=%0d exp=501", out_count); end
    total++; if (out_vote !== 1'b1) begin bad++; $display("FAIL maj501_vote got=%b exp=1", out_vote); end
    release_result();
    drive_vec(ones(500));
    total++; if (out_count !== 10'd500) begin bad++; $display("FAIL maj500_count got=%0d exp=500", out_count); end
    total++; if (out_vote !== 1'b0) begin bad++; $display("FAIL maj500_vote got=%b exp=0", out_vote); end
    release_result();
  endtask

  task automatic test_last_mask();
    logic [1023:0] v;
    v = '0;
    v[15*CHUNK +: CHUNK] = {CHUNK{1'b1}};
    drive_vec(v);
    total++; if (out_count !== 10'd41) begin bad++; $display("FAIL last_mask_count got=%0d exp=41", out_count); end
    total++; if (out_vote !== 1'b0) begin bad++; $display("FAIL last_mask_vote got=%b exp=0", out_vote); end
    release_result();
  endtask

  task automatic test_backpressure();
    drive_vec(ones(700));
    in_valid = 1'b1; in_data = {CHUNK{1'b1}};
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
      total++; if (out_valid !== 1'b1 || out_count !== 10'd700 || out_vote !== 1'b1) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%b/%0d/%b exp=1/700/1", c, out_valid, out_count, out_vote);
      end
    end
    in_data = '0;
    release_result();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_after_ready got=%b exp=1", in_ready); end
    drive_vec(ones(3));
    total++; if (out_count !== 10'd3) begin bad++; $display("FAIL bp_next_count got=%0d exp=3", out_count); end
    release_result();
  endtask

  task automatic test_reset_mid();
    for (int b = 0; b < 7; b++) begin
      in_valid = 1'b1; in_data = {CHUNK{1'b1}};
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready got=%b exp=1", in_ready); end
    drive_vec(~1024'd0);
    total++; if (out_count !== 10'd1001) begin bad++; $display("FAIL mid_reset_count got=%0d exp=1001", out_count); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL done_reset_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL done_reset_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_threshold();
`ifdef VOTER_THRESH_EN
    thr = 10'd900;
    drive_vec(ones(950));
    total++; if (out_vote !== 1'b1) begin bad++; $display("FAIL thr900_950_vote got=%b exp=1", out_vote); end
    release_result();
    drive_vec(ones(899));
    total++; if (out_vote !== 1'b0) begin bad++; $display("FAIL thr900_899_vote got=%b exp=0", out_vote); end
    release_result();
    thr = 10'd0;
    drive_vec('0);
    total++; if (out_vote !== 1'b1) begin bad++; $display("FAIL thr0_zero_vote got=%b exp=1", out_vote); end
    release_result();
`else
    // Fixed rule: thr has no influence.
    thr = 10'd0;
    drive_vec('0);
    total++; if (out_vote !== 1'b0) begin bad++; $display("FAIL fixed_thr0_vote got=%b exp=0", out_vote); end
    release_result();
    thr = 10'd900;
    drive_vec(ones(600));
    total++; if (out_vote !== 1'b1) begin bad++; $display("FAIL fixed_thr900_vote got=%b exp=1", out_vote); end
    release_result();
`endif
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_all_ones();
    test_majority_edge();
    test_last_mask();
    test_backpressure();
    test_reset_mid();
    test_threshold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_majority_voter.md
# stream_majority_voter

Sequential, parametrised successor to the flat combinational majority voter. Accepts a WIDTH-bit vote vector as a stream of CHUNK-bit beats over a valid/ready handshake, accumulates the population count, and emits a single vote bit plus the final count. It sits between a dataset/stimulus source and the result sink, so large vote vectors (e.g. 1001 inputs) no longer need one giant combinational tree.

## Interface
- WIDTH, 1001, total number of vote bits per vector (>= 1)
- CHUNK, 64, vote bits delivered per input beat (1..WIDTH)
- BEATS, ceil(WIDTH/CHUNK) (derived, localparam), beats per vector
- CNT_W, $clog2(WIDTH+1) (derived, localparam), count width
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  beat on in_data is valid
- in_ready  out  1  block accepts a beat this cycle
- in_data  in  CHUNK  vote bits; beat b carries vector bits [b*CHUNK +: CHUNK]
- thr  in  CNT_W  vote threshold (used only with VOTER_THRESH_EN)
- out_valid  out  1  result available
- out_ready  in  1  sink accepts result
- out_vote  out  1  majority/threshold decision
- out_count  out  CNT_W  number of 1s in the vector

## Operation
- States: IDLE, ACCUM, DONE. Beat counter beat_q (0..BEATS-1), accumulator acc_q (CNT_W bits).
- Beat accepted when in_valid && in_ready. in_ready = 1 in IDLE and ACCUM, 0 in DONE.
- IDLE: on accepted beat, acc_q <= popcount(beat), beat_q <= 1, go ACCUM (or DONE directly if BEATS == 1).
- ACCUM: on accepted beat, acc_q += popcount(beat), beat_q++. On accepted beat with beat_q == BEATS-1: go DONE, load out_count with final sum, out_vote from decision rule, out_valid <= 1.
- Last beat masking: only the low WIDTH-(BEATS-1)*CHUNK bits of the final beat are counted; upper bits ignored regardless of value.
- DONE: hold out_valid, out_vote, out_count stable; on out_valid && out_ready, out_valid <= 0, acc_q <= 0, beat_q <= 0, go IDLE.
- Decision rule (default): out_vote = (count >= WIDTH/2 + 1); even WIDTH tie -> 0.
- Arithmetic: accumulation never overflows since count <= WIDTH < 2^CNT_W; no saturation needed.
- in_valid low in ACCUM: state held, no partial timeout.
- Synchronous reset at any point (including mid-vector or in DONE) discards partial vector and pending result.

## Timing
- Reset values: out_valid 0, out_vote 0, out_count 0, in_ready 1 (state IDLE), acc_q 0, beat_q 0.
- Throughput: one beat per cycle when in_valid held high.
- Latency: final beat accepted at edge k -> out_valid, out_vote, out_count valid after edge k (visible cycle k+1).
- Result handshake at edge m -> in_ready high in cycle m+1; minimum BEATS+1 cycles per vector.
- out_* registered; thr sampled at the edge accepting the final beat.

## Configuration
- VOTER_THRESH_EN defined: out_vote = (count >= thr); thr = 0 gives vote 1 always; thr > WIDTH gives vote 0 always.
- Undefined: thr port present but ignored; fixed majority rule above.

## Test plan
- WIDTH=1001, CHUNK=64 (BEATS=16, last beat 41 valid bits), all beats 0xFFFF_FFFF_FFFF_FFFF -> out_count 1001, out_vote 1, out_valid one cycle after 16th beat.
- Vectors with exactly 501 ones then 500 ones -> out_vote 1 / 0, out_count 501 / 500.
- All-zero vector except last beat = all ones -> out_count 41 (bits 63:41 ignored), out_vote 0.
- out_ready held 0 for 5 cycles in DONE with in_valid 1 -> in_ready 0, out_* stable; out_ready 1 -> next cycle in_ready 1, next vector counts from 0.
- rst_n low one cycle after 7 beats, then full all-ones vector -> out_count 1001 (no residue); reset in DONE -> out_valid 0 next cycle.
- VOTER_THRESH_EN, thr=900: 950 ones -> vote 1; 899 ones -> vote 0; thr=0 with all zeros -> vote 1.
